// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill sequencer: arbitrates demand vs prefetch,
// issues one line read to L2 and steers the returning beats into data RAM.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   dmd_req/addr/ack      demand miss request from MSHR, ack pulse
//   pf_req/addr/ack       prefetch request, ack pulse (accepted or dropped)
//   bus_req/addr/ack      L2 read request channel (line-aligned address)
//   bus_rvalid/rdata      L2 read data beats
//   ram_we/addr/beat/wdata  data RAM beat write port
//   linefill_done/src     line complete pulse, source (0 demand, 1 prefetch)
//   busy                  refill in progress
module icache_refill_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int BEATS  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     dmd_req,
   input  logic [ADDR_W-1:0]        dmd_addr,
   output logic                     dmd_ack,
   input  logic                     pf_req,
   input  logic [ADDR_W-1:0]        pf_addr,
   output logic                     pf_ack,
   output logic                     bus_req,
   output logic [ADDR_W-1:0]        bus_addr,
   input  logic                     bus_ack,
   input  logic                     bus_rvalid,
   input  logic [DATA_W-1:0]        bus_rdata,
   output logic                     ram_we,
   output logic [ADDR_W-1:0]        ram_addr,
   output logic [$clog2(BEATS)-1:0] ram_beat,
   output logic [DATA_W-1:0]        ram_wdata,
   output logic                     linefill_done,
   output logic                     linefill_src,
   output logic                     busy
);

   localparam int OFF_W = $clog2(BEATS * DATA_W / 8);
   localparam int BW    = $clog2(BEATS);

   localparam logic [ADDR_W-1:0] LINE_MASK =
      {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      FILL,
      DONE
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] line_q;
   logic [BW-1:0]     cnt_q;
   logic              src_q;

   logic              idle;
   logic              in_req;
   logic              in_fill;
   logic              same_line;
   logic              any_req;
   logic [ADDR_W-1:0] grant_addr;

   assign idle    = (state == IDLE);
   assign in_req  = (state == REQ);
   assign in_fill = (state == FILL);
   assign any_req = dmd_req | pf_req;

   assign same_line =
      (dmd_addr[ADDR_W-1:OFF_W] == pf_addr[ADDR_W-1:OFF_W]);

   // Demand always wins; prefetch only if alone.
   assign grant_addr = dmd_req ? dmd_addr : pf_addr;

   // A prefetch to the line being demand-filled is acked and dropped.
   assign dmd_ack = idle & dmd_req;
   assign pf_ack  = idle & pf_req & (~dmd_req | same_line);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         line_q <= '0;
         cnt_q  <= '0;
         src_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  line_q <= grant_addr & LINE_MASK;
                  src_q  <= ~dmd_req;
                  state  <= REQ;
               end
            end
            REQ: begin
               if (bus_ack) begin
                  cnt_q <= '0;
                  state <= FILL;
               end
            end
            FILL: begin
               if (bus_rvalid) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST_BEAT) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus_req  = in_req;
   assign bus_addr = in_req ? line_q : '0;

   // Beats outside FILL (stray or coincident with bus_ack) never write.
   assign ram_we    = in_fill & bus_rvalid;
   assign ram_addr  = in_fill ? line_q : '0;
   assign ram_beat  = in_fill ? cnt_q : '0;
   assign ram_wdata = ram_we ? bus_rdata : '0;

   assign linefill_done = (state == DONE);
   assign linefill_src  = src_q;
   assign busy          = ~idle;

endmodule
